ramp_setpoint: RTL and testbench

RAMP_SETPOINT -- requirements
Module: ramp_setpoint

---
 rtl/ramp_setpoint_pkg.sv | 13 +
 rtl/ramp_step.sv | 35 +++
 rtl/ramp_setpoint.sv | 89 ++++++++
 tb/tb_ramp_setpoint.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/ramp_setpoint_pkg.sv
// Shared types and default sizing for the slew-limited setpoint ramp.
package ramp_setpoint_pkg;

  localparam int unsigned DEF_DATA_WIDTH = 10;
  localparam int unsigned DEF_STEP       = 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RAMP_UP   = 2'd1,
    RAMP_DOWN = 2'd2
  } state_e;

endpackage

// File: rtl/ramp_step.sv
// Combinational saturating step: moves cur toward tgt by at most STEP without
// overshooting tgt or wrapping past either end of the range.
module ramp_step
  import ramp_setpoint_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned STEP       = DEF_STEP
) (
  input  logic [DATA_WIDTH-1:0] cur,
  input  logic [DATA_WIDTH-1:0] tgt,
  input  logic                  dir,
  output logic [DATA_WIDTH-1:0] nxt
);

  localparam int unsigned EXT_WIDTH = DATA_WIDTH + 1;
  localparam logic [DATA_WIDTH:0] STEP_EXT = EXT_WIDTH'(STEP);

  logic        [DATA_WIDTH:0] sum;
  logic signed [DATA_WIDTH:0] diff;
  logic signed [DATA_WIDTH:0] tgt_s;

  // One extra bit keeps the sum from wrapping and the difference from underflowing.
  always_comb begin
    sum   = {1'b0, cur} + STEP_EXT;
    diff  = $signed({1'b0, cur}) - $signed(STEP_EXT);
    tgt_s = $signed({1'b0, tgt});
    nxt   = tgt;
    if (dir) begin
      if (sum < {1'b0, tgt}) nxt = sum[DATA_WIDTH-1:0];
    end else begin
      if (diff > tgt_s) nxt = diff[DATA_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/ramp_setpoint.sv
// Slew-limited setpoint generator: accepts a target in IDLE and walks ramp_out
// toward it by at most STEP per clock, with hold/abort control and a done pulse.
module ramp_setpoint
  import ramp_setpoint_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned STEP       = DEF_STEP
) (
  input  logic                  clock_1khz,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] target,
  input  logic                  target_valid,
  output logic                  target_ready,
  input  logic                  hold,
  input  logic                  abort,
  output logic [DATA_WIDTH-1:0] ramp_out,
  output logic                  busy,
  output logic                  done
);

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   ramp_q, ramp_d;
  logic [DATA_WIDTH-1:0]   tgt_q, tgt_d;
  logic                    done_q, done_d;
  logic [DATA_WIDTH-1:0]   step_nxt;
  logic                    step_up;

  assign step_up = (state_q == RAMP_UP);

  ramp_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .STEP       (STEP)
  ) u_step (
    .cur (ramp_q),
    .tgt (tgt_q),
    .dir (step_up),
    .nxt (step_nxt)
  );

  always_ff @(posedge clock_1khz or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      ramp_q  <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ramp_q  <= ramp_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  // Abort outranks hold, which outranks stepping; the accepting edge never moves ramp_out.
  always_comb begin
    state_d = state_q;
    ramp_d  = ramp_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (target_valid) begin
          tgt_d = target;
          if (target > ramp_q)      state_d = RAMP_UP;
          else if (target < ramp_q) state_d = RAMP_DOWN;
          else                      done_d  = 1'b1;
        end
      end
      RAMP_UP, RAMP_DOWN: begin
        if (abort) begin
          state_d = IDLE;
        end else if (!hold) begin
          ramp_d = step_nxt;
          if (step_nxt == tgt_q) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ramp_out     = ramp_q;
  assign done         = done_q;
  assign target_ready = (state_q == IDLE);
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_ramp_setpoint.sv
// Bench for ramp_setpoint: table of per-cycle vectors plus long-ramp sequences,
// expectations queued at drive time and compared when outputs are sampled.
module tb_ramp_setpoint;

  localparam int unsigned DW   = 10;
  localparam int          STEP = 4;

  logic          clock_1khz   = 1'b0;
  logic          rst          = 1'b0;
  logic [DW-1:0] target       = '0;
  logic          target_valid = 1'b0;
  logic          hold         = 1'b0;
  logic          abort        = 1'b0;
  logic          target_ready;
  logic [DW-1:0] ramp_out;
  logic          busy;
  logic          done;

  ramp_setpoint #(
    .DATA_WIDTH (DW),
    .STEP       (STEP)
  ) dut (
    .clock_1khz   (clock_1khz),
    .rst          (rst),
    .target       (target),
    .target_valid (target_valid),
    .target_ready (target_ready),
    .hold         (hold),
    .abort        (abort),
    .ramp_out     (ramp_out),
    .busy         (busy),
    .done         (done)
  );

  always #5 clock_1khz = ~clock_1khz;

  typedef struct {
    logic          r;
    logic          v;
    logic [DW-1:0] t;
    logic          h;
    logic          a;
    logic [DW-1:0] er;
    logic          eb;
    logic          erd;
    logic          ed;
  } vec_t;

  typedef struct {
    logic [DW-1:0] ramp;
    logic          busy;
    logic          ready;
    logic          done;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   mr;

  function automatic vec_t mk(input int r, input int v, input int t, input int h, input int a,
                              input int er, input int eb, input int erd, input int ed);
    vec_t x;
    x.r = r[0]; x.v = v[0]; x.t = DW'(t); x.h = h[0]; x.a = a[0];
    x.er = DW'(er); x.eb = eb[0]; x.erd = erd[0]; x.ed = ed[0];
    return x;
  endfunction

  task automatic cmp_bit(input string tag, input string what, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s %s got %0b want %0b", tag, what, act, exp);
    end
  endtask

  task automatic cmp_int(input string tag, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d want %0d", tag, act, exp);
    end
  endtask

  task automatic check_out(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL %s scoreboard empty got nothing want entry", tag);
    end else begin
      e = sb.pop_front();
      checks++;
      if (ramp_out !== e.ramp) begin
        errors++;
        $display("FAIL %s ramp_out got %0d want %0d", tag, ramp_out, e.ramp);
      end
      cmp_bit(tag, "busy", busy, e.busy);
      cmp_bit(tag, "target_ready", target_ready, e.ready);
      cmp_bit(tag, "done", done, e.done);
    end
  endtask

  // Drive at the falling edge, let one rising edge act, sample at the next falling edge.
  task automatic apply(input logic r, input logic v, input logic [DW-1:0] t, input logic h,
                       input logic a, input exp_t e, input string tag);
    rst = r; target_valid = v; target = t; hold = h; abort = a;
    sb.push_back(e);
    @(posedge clock_1khz);
    @(negedge clock_1khz);
    check_out(tag);
  endtask

  task automatic ramp_to(input int t, input int exp_busy_cycles, input string name);
    exp_t e;
    int   nb;
    int   nd;
    bit   up;
    nb = 0; nd = 0; up = (t > mr);
    e.ramp = DW'(mr); e.busy = (t != mr); e.ready = (t == mr); e.done = (t == mr);
    apply(1'b0, 1'b1, DW'(t), 1'b0, 1'b0, e, $sformatf("%s accept", name));
    nb += int'(busy); nd += int'(done);
    for (int k = 0; k < 2000 && mr != t; k++) begin
      if (up) mr = (mr + STEP > t) ? t : mr + STEP;
      else    mr = (mr - STEP < t) ? t : mr - STEP;
      e.ramp = DW'(mr); e.busy = (mr != t); e.ready = (mr == t); e.done = (mr == t);
      apply(1'b0, 1'b0, '0, 1'b0, 1'b0, e, $sformatf("%s step%0d", name, k));
      nb += int'(busy); nd += int'(done);
    end
    e.ramp = DW'(mr); e.busy = 1'b0; e.ready = 1'b1; e.done = 1'b0;
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, e, $sformatf("%s settle", name));
    nb += int'(busy); nd += int'(done);
    cmp_int($sformatf("%s busy_cycles", name), nb, exp_busy_cycles);
    cmp_int($sformatf("%s done_pulses", name), nd, 1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    // reset, equal-target acceptance, basic 0->10 ramp with ignored mid-ramp offer
    tbl.push_back(mk(1, 0,   0, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 1,   0, 0, 0,   0, 0, 1, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 1,  10, 0, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   4, 1, 0, 0));
    tbl.push_back(mk(0, 1, 500, 0, 0,   8, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  10, 0, 1, 1));
    tbl.push_back(mk(0, 0,   0, 1, 1,  10, 0, 1, 0));
    // ramp down 10->0 with final partial step
    tbl.push_back(mk(0, 1,   0, 0, 0,  10, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   6, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   2, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   0, 0, 1, 1));
    // 0->100, hold 5 cycles at 20, abort at 40 with hold also high
    tbl.push_back(mk(0, 1, 100, 0, 0,   0, 1, 0, 0));
    for (int v = 4; v <= 20; v += 4) tbl.push_back(mk(0, 0, 0, 0, 0, v, 1, 0, 0));
    for (int i = 0; i < 5; i++)      tbl.push_back(mk(0, 0, 0, 1, 0, 20, 1, 0, 0));
    for (int v = 24; v <= 40; v += 4) tbl.push_back(mk(0, 0, 0, 0, 0, v, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 1,  40, 0, 1, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,  40, 0, 1, 0));
    // reset mid-ramp at 60 toward 200, then accept on the first edge after release
    tbl.push_back(mk(0, 1, 200, 0, 0,  40, 1, 0, 0));
    for (int v = 44; v <= 60; v += 4) tbl.push_back(mk(0, 0, 0, 0, 0, v, 1, 0, 0));
    tbl.push_back(mk(1, 1, 200, 0, 0,   0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 200, 0, 0,   0, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   4, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 1,   4, 0, 1, 0));
    // hold on the would-be final step delays done
    tbl.push_back(mk(0, 1,   6, 0, 0,   4, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 1, 0,   4, 1, 0, 0));
    tbl.push_back(mk(0, 0,   0, 0, 0,   6, 0, 1, 1));
    tbl.push_back(mk(0, 0,   0, 0, 0,   6, 0, 1, 0));

    @(negedge clock_1khz);
    foreach (tbl[i]) begin
      e.ramp = tbl[i].er; e.busy = tbl[i].eb; e.ready = tbl[i].erd; e.done = tbl[i].ed;
      apply(tbl[i].r, tbl[i].v, tbl[i].t, tbl[i].h, tbl[i].a, e, $sformatf("row%0d", i));
    end

    mr = 6;
    ramp_to(1020, 254, "up_to_1020");
    ramp_to(1023, 1,   "top_1020_1023");
    ramp_to(0,    256, "down_1023_0");
    ramp_to(0,    0,   "equal_0");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
